// File: rtl/nor_exhaustive_checker.sv
// Exhaustive stimulus/response checker for N-input NOR cells: sweeps every input vector, compares against ~|vec.
// Optional build macro NOR_CHECKER_XZ_CHECK_EN adds a sticky x/z sample indicator on xz_seen.
module nor_exhaustive_checker #(
   parameter int N_INPUTS      = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic [N_INPUTS-1:0] drive,
   input  logic                dut_out,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [7:0]          err_count,
   output logic [N_INPUTS-1:0] first_fail_vec,
   output logic                fail_seen,
   output logic                xz_seen
);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;

   state_t              state, state_nxt;
   logic [N_INPUTS-1:0] vec;
   logic [3:0]          pass_cnt;
   logic [3:0]          settle_cnt;
   logic                expected;
   logic                mismatch;
   logic                last_vec;
   logic                last_pass;
   logic [7:0]          err_inc;

   assign expected  = ~|vec;
   assign mismatch  = (dut_out !== expected);
   assign last_vec  = &vec;
   assign last_pass = (pass_cnt == 4'(PASSES - 1));
   assign err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

   assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DRIVE;
         DRIVE:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == 4'd1) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (last_vec && last_pass) ? DONE : DRIVE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drive          <= '0;
         pass           <= 1'b0;
         err_count      <= 8'd0;
         first_fail_vec <= '0;
         fail_seen      <= 1'b0;
         vec            <= '0;
         pass_cnt       <= 4'd0;
         settle_cnt     <= 4'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               pass           <= 1'b0;
               err_count      <= 8'd0;
               first_fail_vec <= '0;
               fail_seen      <= 1'b0;
               vec            <= '0;
               pass_cnt       <= 4'd0;
            end
            DRIVE: begin
               drive      <= vec;
               settle_cnt <= 4'(SETTLE_CYCLES);
            end
            SETTLE: settle_cnt <= settle_cnt - 4'd1;
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_inc;
                  if (!fail_seen) begin
                     first_fail_vec <= vec;
                     fail_seen      <= 1'b1;
                  end
               end
               if (!last_vec) begin
                  vec <= vec + 1'b1;
               end else if (!last_pass) begin
                  vec      <= '0;
                  pass_cnt <= pass_cnt + 4'd1;
               end else begin
                  // Resolved on entry to DONE so pass is already valid while done is high.
                  pass <= (err_count == 8'd0) && !mismatch;
               end
            end
            DONE: drive <= '0;
            default: ;
         endcase
      end
   end

`ifdef NOR_CHECKER_XZ_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)
         xz_seen <= 1'b0;
      else if (state == IDLE && start)
         xz_seen <= 1'b0;
      else if (state == SAMPLE && (dut_out !== 1'b0) && (dut_out !== 1'b1))
         xz_seen <= 1'b1;
   end
`else
   assign xz_seen = 1'b0;
`endif

endmodule

// File: tb/tb_nor_exhaustive_checker.sv
// Table-driven bench for nor_exhaustive_checker: three parameterisations, NOR models with injected faults.
module tb_nor_exhaustive_checker;

`ifdef NOR_CHECKER_XZ_CHECK_EN
   localparam int XZ_EXP = 1;
`else
   localparam int XZ_EXP = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic start_r [3];
   int   mode_r  [3];

   logic [1:0] drive0, ffv0;
   logic [1:0] drive1, ffv1;
   logic [2:0] drive2, ffv2;
   logic [7:0] err0, err1, err2;
   logic busy0, done0, pass0, fs0, xz0;
   logic busy1, done1, pass1, fs1, xz1;
   logic busy2, done2, pass2, fs2, xz2;

   // Mode 0 good NOR, 1 stuck-at-1, 2 stuck-at-0, 3 floating output when all inputs low.
   function automatic logic nor_model(input int mode, input logic [3:0] d);
      case (mode)
         1:       return 1'b1;
         2:       return 1'b0;
         default: return ~|d;
      endcase
   endfunction

   wire dut_out0 = (mode_r[0] == 3 && drive0 == 2'b00) ? 1'bz : nor_model(mode_r[0], {2'b00, drive0});
   wire dut_out1 = (mode_r[1] == 3 && drive1 == 2'b00) ? 1'bz : nor_model(mode_r[1], {2'b00, drive1});
   wire dut_out2 = (mode_r[2] == 3 && drive2 == 3'b000) ? 1'bz : nor_model(mode_r[2], {1'b0, drive2});

   nor_exhaustive_checker #(.N_INPUTS(2), .SETTLE_CYCLES(2), .PASSES(1)) u0 (
      .clk(clk), .reset(reset), .start(start_r[0]), .drive(drive0), .dut_out(dut_out0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail_vec(ffv0), .fail_seen(fs0), .xz_seen(xz0));

   nor_exhaustive_checker #(.N_INPUTS(2), .SETTLE_CYCLES(2), .PASSES(2)) u1 (
      .clk(clk), .reset(reset), .start(start_r[1]), .drive(drive1), .dut_out(dut_out1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_vec(ffv1), .fail_seen(fs1), .xz_seen(xz1));

   nor_exhaustive_checker #(.N_INPUTS(3), .SETTLE_CYCLES(2), .PASSES(1)) u2 (
      .clk(clk), .reset(reset), .start(start_r[2]), .drive(drive2), .dut_out(dut_out2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_vec(ffv2), .fail_seen(fs2), .xz_seen(xz2));

   logic       busy_w [3];
   logic       done_w [3];
   logic       pass_w [3];
   logic       fs_w   [3];
   logic       xz_w   [3];
   logic [7:0] err_w  [3];
   logic [3:0] drv_w  [3];
   logic [3:0] ffv_w  [3];

   always_comb begin
      busy_w[0] = busy0; busy_w[1] = busy1; busy_w[2] = busy2;
      done_w[0] = done0; done_w[1] = done1; done_w[2] = done2;
      pass_w[0] = pass0; pass_w[1] = pass1; pass_w[2] = pass2;
      fs_w[0]   = fs0;   fs_w[1]   = fs1;   fs_w[2]   = fs2;
      xz_w[0]   = xz0;   xz_w[1]   = xz1;   xz_w[2]   = xz2;
      err_w[0]  = err0;  err_w[1]  = err1;  err_w[2]  = err2;
      drv_w[0]  = {2'b00, drive0}; drv_w[1] = {2'b00, drive1}; drv_w[2] = {1'b0, drive2};
      ffv_w[0]  = {2'b00, ffv0};   ffv_w[1] = {2'b00, ffv1};   ffv_w[2] = {1'b0, ffv2};
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // start2: cycle of an extra start pulse (0 = none); rst_at: cycle reset is held (0 = none).
   typedef struct {
      int sel; int mode; int start2; int rst_at;
      int exp_done; int exp_err; int exp_pass; int exp_fs; int exp_ffv; int exp_xz;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int dc;
      tbl[0] = '{0, 0, 0, 0,  17, 0, 1, 0, 0, 0};
      tbl[1] = '{0, 1, 0, 0,  17, 3, 0, 1, 1, 0};
      tbl[2] = '{0, 2, 0, 0,  17, 1, 0, 1, 0, 0};
      tbl[3] = '{0, 3, 0, 0,  17, 1, 0, 1, 0, XZ_EXP};
      tbl[4] = '{1, 1, 5, 0,  33, 6, 0, 1, 1, 0};
      tbl[5] = '{2, 0, 0, 0,  33, 0, 1, 0, 0, 0};
      tbl[6] = '{2, 1, 0, 10, -1, 0, 0, 0, 0, 0};

      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_r[i] = 1'b0;
         mode_r[i]  = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_pass", int'(pass0), 0);
      chk("rst_err", int'(err0), 0);
      chk("rst_ffv", int'(ffv0), 0);
      chk("rst_fail_seen", int'(fs0), 0);
      chk("rst_xz", int'(xz0), 0);
      chk("rst_drive", int'(drive0), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int r = 0; r < 7; r++) begin
         int s;
         s = tbl[r].sel;
         mode_r[s]  = tbl[r].mode;
         start_r[s] = 1'b1;
         dc = -1;
         for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start_r[s] = (k == tbl[r].start2);
            reset      = (k == tbl[r].rst_at);
            if (done_w[s] && dc < 0) begin
               dc = k;
               chk($sformatf("r%0d_pass_at_done", r), int'(pass_w[s]), tbl[r].exp_pass);
               chk($sformatf("r%0d_busy_at_done", r), int'(busy_w[s]), 0);
            end
            if (k == 1) chk($sformatf("r%0d_busy_c1", r), int'(busy_w[s]), 1);
            if (r == 0 && (k == 2 || k == 6 || k == 10 || k == 14))
               chk($sformatf("r0_drive_c%0d", k), int'(drv_w[s]), (k - 2) / 4);
            if (r == 0 && k == 18) chk("r0_drive_after_done", int'(drv_w[s]), 0);
            if (tbl[r].rst_at != 0 && k == tbl[r].rst_at - 1)
               chk($sformatf("r%0d_err_before_rst", r), int'(err_w[s]), 1);
            if (tbl[r].rst_at != 0 && k == tbl[r].rst_at + 1) begin
               chk($sformatf("r%0d_rst_busy", r), int'(busy_w[s]), 0);
               chk($sformatf("r%0d_rst_drive", r), int'(drv_w[s]), 0);
               chk($sformatf("r%0d_rst_err", r), int'(err_w[s]), 0);
            end
         end
         reset = 1'b0;
         chk($sformatf("r%0d_done_cycle", r), dc, tbl[r].exp_done);
         chk($sformatf("r%0d_err", r), int'(err_w[s]), tbl[r].exp_err);
         chk($sformatf("r%0d_pass_held", r), int'(pass_w[s]), tbl[r].exp_pass);
         chk($sformatf("r%0d_fail_seen", r), int'(fs_w[s]), tbl[r].exp_fs);
         chk($sformatf("r%0d_ffv", r), int'(ffv_w[s]), tbl[r].exp_ffv);
         chk($sformatf("r%0d_xz", r), int'(xz_w[s]), tbl[r].exp_xz);
         chk($sformatf("r%0d_idle_busy", r), int'(busy_w[s]), 0);
         mode_r[s] = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
